mux_n_channel_sel: RTL
======================

# mux_n_channel_sel

Parametrised N-channel, W-bit registered selector with a sticky, latchable select register, used to steer register-file contents (R0–R15) onto the ALU source bus in the SuperFX datapath. A select value is loaded by a prefix strobe, held across cycles, and returned to a default channel by an end-of-instruction clear. The output is registered and can be frozen during pipeline stalls; out-of-range selects are rejected and flagged.

## Interface
- WIDTH, 16, bit width of each channel and of the output
- CHANNELS, 16, number of input channels (2..16, need not be a power of 2)
- SEL_W, $clog2(CHANNELS), width of select fields
- DEFAULT_SEL, 0, channel selected after reset and after sel_clear; must be < CHANNELS
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- data_input  in  CHANNELS*WIDTH  flattened channels; channel k at bits [k*WIDTH +: WIDTH]
- sel_load  in  1  one-cycle strobe: latch sel_value as current select
- sel_value  in  SEL_W  channel index to latch
- sel_clear  in  1  one-cycle strobe: revert to DEFAULT_SEL
- hold  in  1  freeze selected_output (stall)
- selected_output  out  WIDTH  registered selected channel data
- selected_index  out  SEL_W  current select register
- sel_sticky  out  1  1 while a loaded (non-default) select is active
- sel_error  out  1  one-cycle pulse: rejected out-of-range load

## Operation
- State: cur_sel (SEL_W), sticky (1), out_reg (WIDTH), err (1).
- Two-state select FSM: DEFAULT (sticky=0, cur_sel=DEFAULT_SEL) and LOADED (sticky=1, cur_sel=latched value).
  - DEFAULT/LOADED + valid sel_load -> LOADED, cur_sel <= sel_value.
  - LOADED + sel_clear (no valid load) -> DEFAULT.
  - DEFAULT + sel_clear -> DEFAULT (no-op).
  - LOADED + valid sel_load -> LOADED with new value (re-prefix overrides).
- Valid load: sel_value < CHANNELS. Invalid load: state unchanged, sel_error=1 next cycle; a concurrent sel_clear still takes effect.
- Simultaneous valid sel_load and sel_clear: load wins (new prefix arriving at instruction boundary).
- Output: out_reg <= channel[cur_sel] every cycle when hold=0; holds value when hold=1. hold does not block select updates.
- Reset: selected_output=0, selected_index=DEFAULT_SEL, sel_sticky=0, sel_error=0. Reset mid-operation discards any loaded select and overrides all strobes in that cycle.

## Timing
- data_input -> selected_output: 1 cycle (hold=0).
- sel_load at edge N: selected_index/sel_sticky updated after edge N; selected_output reflects new channel after edge N+1 (2-cycle latency) without bypass macro.
- sel_clear: same latencies as sel_load.
- sel_error asserted exactly the cycle after the invalid load, deasserted next cycle unless another invalid load.
- No combinational path from any input to any output.

## Configuration
- MUX_SEL_BYPASS_EN defined: output mux indexes with next-state select (cur_sel_next), so sel_load/sel_clear reach selected_output after edge N (1-cycle latency); selected_index timing unchanged.
- Undefined: output mux indexes registered cur_sel (2-cycle latency as above).

## Structure
- Shared package superfx_mux_pkg: clog2 function, SEL_W derivation, DEFAULT_SEL constant for ALU source (0) and destination (0), register-index constants R0..R15.
- One sub-module: mux_n_comb — purely combinational CHANNELS:1 WIDTH-bit slice selector (data_input, index -> data); top wraps it with select FSM, range check, and output register.

## Test plan
- Reset with data_input channel k = 16'h1000+k -> after first edge with reset=0, selected_output=16'h1000, selected_index=0, sel_sticky=0.
- sel_load with sel_value=5 at edge N -> selected_index=5, sel_sticky=1 after N; selected_output=16'h1005 after N+1 (after N with MUX_SEL_BYPASS_EN).
- LOADED (sel=5), sel_load=1 sel_value=9 and sel_clear=1 same cycle -> selected_index=9, sel_sticky=1; then sel_clear alone -> index=0, sticky=0.
- CHANNELS=12, sel_load sel_value=13 -> sel_error pulses one cycle, selected_index unchanged, sel_sticky unchanged.
- hold=1 for 3 cycles while channel 5 changes 16'h1005->16'hBEEF and sel_load to 7 -> selected_output stays 16'h1005, selected_index=7; hold=0 -> output 16'h1007 next cycle.
- reset asserted in LOADED state concurrent with sel_load=3 -> all outputs at reset values, selected_index=0.

Source files
------------

// File: rtl/mux_n_channel_sel_pkg.sv
// Shared constants for the SuperFX ALU source/destination selectors.
// Provides the select-width helper, default channels and R0..R15 indices.
package superfx_mux_pkg;

    typedef enum logic {
        SEL_DEFAULT = 1'b0,
        SEL_LOADED  = 1'b1
    } sel_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Select fields never collapse to zero bits, even for a single channel.
    function automatic int sel_width(input int channels);
        return (clog2(channels) < 1) ? 1 : clog2(channels);
    endfunction

    localparam int ALU_SRC_DEFAULT_SEL = 0;
    localparam int ALU_DST_DEFAULT_SEL = 0;

    localparam logic [3:0] R0  = 4'd0;
    localparam logic [3:0] R1  = 4'd1;
    localparam logic [3:0] R2  = 4'd2;
    localparam logic [3:0] R3  = 4'd3;
    localparam logic [3:0] R4  = 4'd4;
    localparam logic [3:0] R5  = 4'd5;
    localparam logic [3:0] R6  = 4'd6;
    localparam logic [3:0] R7  = 4'd7;
    localparam logic [3:0] R8  = 4'd8;
    localparam logic [3:0] R9  = 4'd9;
    localparam logic [3:0] R10 = 4'd10;
    localparam logic [3:0] R11 = 4'd11;
    localparam logic [3:0] R12 = 4'd12;
    localparam logic [3:0] R13 = 4'd13;
    localparam logic [3:0] R14 = 4'd14;
    localparam logic [3:0] R15 = 4'd15;

endpackage

// File: rtl/mux_n_channel_sel_if.sv
// Bus bundle between the selector and its datapath neighbours.
// master drives channels and select strobes; slave is the selector.
interface mux_n_channel_sel_if
    import superfx_mux_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 16,
    parameter int SEL_W    = sel_width(CHANNELS)
);
    logic [CHANNELS*WIDTH-1:0] data_input;
    logic                      sel_load;
    logic [SEL_W-1:0]          sel_value;
    logic                      sel_clear;
    logic                      hold;
    logic [WIDTH-1:0]          selected_output;
    logic [SEL_W-1:0]          selected_index;
    logic                      sel_sticky;
    logic                      sel_error;

    modport master (
        output data_input, sel_load, sel_value, sel_clear, hold,
        input  selected_output, selected_index, sel_sticky, sel_error
    );

    modport slave (
        input  data_input, sel_load, sel_value, sel_clear, hold,
        output selected_output, selected_index, sel_sticky, sel_error
    );
endinterface

// File: rtl/mux_n_channel_sel_comb.sv
// Purpose: CHANNELS:1 WIDTH-bit slice selector over a flattened channel bus.
// Latency: combinational. Backpressure: none.
module mux_n_comb #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 16,
    parameter int SEL_W    = 4
) (
    input  logic [CHANNELS*WIDTH-1:0] data_input,
    input  logic [SEL_W-1:0]          index,
    output logic [WIDTH-1:0]          data
);
    always_comb begin
        data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (index == SEL_W'(k)) begin
                data = data_input[k*WIDTH +: WIDTH];
            end
        end
    end
endmodule

// File: rtl/mux_n_channel_sel.sv
// Purpose: sticky-select registered N:1 selector; MUX_SEL_BYPASS_EN feeds the next select to the mux.
// Latency: data 1 cycle; select change 2 cycles (1 with MUX_SEL_BYPASS_EN). Backpressure: hold freezes output only.
module mux_n_channel_sel
    import superfx_mux_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int CHANNELS    = 16,
    parameter int SEL_W       = sel_width(CHANNELS),
    parameter int DEFAULT_SEL = ALU_SRC_DEFAULT_SEL
) (
    input  logic clk,
    input  logic reset,
    mux_n_channel_sel_if.slave bus
);
    localparam logic [SEL_W-1:0] DEFAULT_SEL_V = SEL_W'(DEFAULT_SEL);
    // One extra bit so CHANNELS == 2**SEL_W still compares correctly.
    localparam logic [SEL_W:0]   CHAN_LIMIT    = (SEL_W+1)'(CHANNELS);

    sel_state_t        state;
    sel_state_t        state_next;
    logic [SEL_W-1:0]  cur_sel;
    logic [SEL_W-1:0]  cur_sel_next;
    logic [SEL_W-1:0]  mux_idx;
    logic [WIDTH-1:0]  mux_data;
    logic [WIDTH-1:0]  out_reg;
    logic              sticky;
    logic              err;
    logic              load_valid;

    always_comb begin
        load_valid   = bus.sel_load && ({1'b0, bus.sel_value} < CHAN_LIMIT);
        state_next   = state;
        cur_sel_next = cur_sel;
        // A valid prefix beats the end-of-instruction clear.
        if (load_valid) begin
            state_next   = SEL_LOADED;
            cur_sel_next = bus.sel_value;
        end else if (bus.sel_clear) begin
            state_next   = SEL_DEFAULT;
            cur_sel_next = DEFAULT_SEL_V;
        end
    end

`ifdef MUX_SEL_BYPASS_EN
    assign mux_idx = cur_sel_next;
`else
    assign mux_idx = cur_sel;
`endif

    mux_n_comb #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_mux (
        .data_input (bus.data_input),
        .index      (mux_idx),
        .data       (mux_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= SEL_DEFAULT;
            cur_sel <= DEFAULT_SEL_V;
            sticky  <= 1'b0;
            err     <= 1'b0;
            out_reg <= '0;
        end else begin
            state   <= state_next;
            cur_sel <= cur_sel_next;
            sticky  <= (state_next == SEL_LOADED);
            err     <= bus.sel_load && !load_valid;
            if (!bus.hold) begin
                out_reg <= mux_data;
            end
        end
    end

    assign bus.selected_output = out_reg;
    assign bus.selected_index  = cur_sel;
    assign bus.sel_sticky      = sticky;
    assign bus.sel_error       = err;
endmodule
